// File: rtl/raster_pkg.sv
// Shared constants and FSM state type for the raster fill path.
package raster_pkg;

   localparam int unsigned DIM = 64;
   localparam int unsigned Y_W = $clog2(DIM);

   typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;

endpackage

// File: rtl/scanline_filler_span_finder.sv
// Combinational span finder: lowest/highest set bit of a row and the solid mask between them.
module span_finder #(
   parameter int unsigned W = 64
) (
   input  logic [W-1:0]         row,
   output logic                 any,
   output logic [$clog2(W)-1:0] lo,
   output logic [$clog2(W)-1:0] hi,
   output logic [W-1:0]         mask
);

   localparam int unsigned LW = $clog2(W);

   always_comb begin
      any  = |row;
      lo   = '0;
      hi   = '0;
      mask = '0;
      // Priority encoders from each end: the last write in each loop wins.
      for (int i = W - 1; i >= 0; i--) begin
         if (row[i]) lo = LW'(i);
      end
      for (int i = 0; i < W; i++) begin
         if (row[i]) hi = LW'(i);
      end
      for (int i = 0; i < W; i++) begin
         mask[i] = any && (LW'(i) >= lo) && (LW'(i) <= hi);
      end
   end

endmodule

// File: rtl/scanline_filler.sv
// Walks a captured outline bitmap row by row and streams each row out, raw or span-filled.
module scanline_filler #(
   parameter int unsigned DIM        = raster_pkg::DIM,
   parameter bit          SKIP_EMPTY = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    fill_en,
   input  logic [DIM*DIM-1:0]      line_buffer,
   output logic                    row_valid,
   input  logic                    row_ready,
   output logic [$clog2(DIM)-1:0]  row_y,
   output logic [DIM-1:0]          row_data,
   output logic                    busy,
   output logic                    done
);

   import raster_pkg::*;

   localparam int unsigned    YW     = $clog2(DIM);
   localparam logic [YW-1:0]  Y_LAST = YW'(DIM - 1);

   state_t              state_q, state_d;
   logic [DIM*DIM-1:0]  snap_q;
   logic                fill_q;
   logic [YW-1:0]       y_q, y_d;
   logic [YW-1:0]       row_y_q, row_y_d;
   logic [DIM-1:0]      row_data_q, row_data_d;
   logic [DIM-1:0]      cur_row, span_mask;
   logic [YW-1:0]       span_lo, span_hi;
   logic                span_any;
   logic                capture;
   logic                unused_span;

   assign capture     = (state_q == IDLE) && start;
   assign cur_row     = snap_q[int'(y_q) * DIM +: DIM];
   assign unused_span = ^{span_lo, span_hi};

   span_finder #(
      .W (DIM)
   ) u_span (
      .row  (cur_row),
      .any  (span_any),
      .lo   (span_lo),
      .hi   (span_hi),
      .mask (span_mask)
   );

   always_comb begin
      state_d    = state_q;
      y_d        = y_q;
      row_y_d    = row_y_q;
      row_data_d = row_data_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               y_d     = '0;
            end
         end
         SCAN: begin
            row_data_d = fill_q ? span_mask : cur_row;
            row_y_d    = y_q;
            if (SKIP_EMPTY && !span_any) begin
               if (y_q == Y_LAST) state_d = FIN;
               else               y_d     = y_q + YW'(1);
            end else begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (row_ready) begin
               if (y_q == Y_LAST) begin
                  state_d = FIN;
               end else begin
                  y_d     = y_q + YW'(1);
                  state_d = SCAN;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         snap_q     <= '0;
         fill_q     <= 1'b0;
         y_q        <= '0;
         row_y_q    <= '0;
         row_data_q <= '0;
      end else begin
         state_q    <= state_d;
         y_q        <= y_d;
         row_y_q    <= row_y_d;
         row_data_q <= row_data_d;
         if (capture) begin
            snap_q <= line_buffer;
            fill_q <= fill_en;
         end
      end
   end

   assign row_valid = (state_q == EMIT);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FIN);
   assign row_y     = row_y_q;
   assign row_data  = row_data_q;

endmodule

// File: doc/scanline_filler.md
# scanline_filler

Consumer of the Bresenham line buffer. On a start pulse (driven by `bla_done`), it captures the 64x64 outline bitmap and walks it row by row. For each row it emits either the raw outline or a solid horizontal span between the leftmost and rightmost set pixels. Rows leave through a valid/ready stream to the frame-memory writer, so this block is the read side of the line-buffer interface.

## Interface
- `DIM`, 64: bitmap edge length in pixels; power of two, 8..64; buffer width is DIM*DIM.
- `SKIP_EMPTY`, 0: 1 = rows with no set pixel are not emitted.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  one-cycle pulse; capture `line_buffer` and begin a frame; ignored unless IDLE.
- `fill_en`  in  1  sampled with `start`; 1 = span fill, 0 = pass outline through.
- `line_buffer`  in  DIM*DIM  outline bitmap; pixel (x,y) is bit y*DIM+x.
- `row_valid`  out  1  `row_data`/`row_y` hold a valid row.
- `row_ready`  in  1  downstream accepts the row when `row_valid && row_ready`.
- `row_y`  out  log2(DIM)  row index of `row_data`.
- `row_data`  out  DIM  row pixels; bit x = column x.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last row is accepted or skipped.

## Operation
- Only `start` captures `line_buffer`, into a DIM*DIM snapshot register; later input changes have no effect on the frame.
- `fill_en` is latched into `fill_q` at the same edge.
- States: IDLE, SCAN, EMIT, FIN.
- IDLE: `start` captures, clears row counter `y` to 0, and moves to SCAN.
- SCAN: reads snapshot row `y` and registers the result into `row_data`/`row_y`.
  - If `SKIP_EMPTY`=1 and the row is empty: stay in SCAN with y+1, or go to FIN when y = DIM-1.
  - Otherwise: go to EMIT.
- EMIT: `row_valid`=1; `row_data`/`row_y` stay stable until the handshake.
  - On handshake with y = DIM-1: go to FIN.
  - On handshake otherwise: y+1, go to SCAN.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- Row function with `fill_q`=1, where L is the lowest set index and R the highest: bits L..R = 1, all others 0. An empty row gives all zeros; a single pixel gives a one-bit span.
- Row function with `fill_q`=0: `row_data` = raw snapshot row.
- `y` is log2(DIM) bits wide. It never wraps within a frame; the terminal test is on DIM-1.
- `start` while busy: ignored. No restart and no queuing.
- `row_ready` outside EMIT: ignored.
- `rst` at any time, including mid-frame: next state IDLE, the frame is abandoned, and no `done` is generated.

## Timing
- Reset values: `row_valid`=0, `row_y`=0, `row_data`=0, `busy`=0, `done`=0. Snapshot and `fill_q` are cleared.
- `start` at edge N: `busy`=1 after N, row 0 is computed at N+1, and `row_valid`=1 after N+1. First-row latency is 2 cycles.
- Throughput: 2 cycles per emitted row when `row_ready` is held high, so a full frame takes 2*DIM cycles plus FIN.
- A skipped row costs 1 cycle.
- `done` is asserted in the cycle after the final accept or skip. `busy` drops in the cycle after `done`.
- `row_valid` never deasserts without a handshake, and data is never changed while `row_valid`=1 (AXI-stream rule).

## Structure
- Package `raster_pkg`: `DIM` default constant, `Y_W = $clog2(DIM)`, and the state enum `{IDLE, SCAN, EMIT, FIN}`.
- Sub-module `span_finder`: combinational, DIM-bit row in; outputs `any`, `lo`, `hi`, and the filled mask.
  - Used once in SCAN.
  - Built from a parameterised priority encoder run from each end.
- Top level holds the FSM, snapshot register, row counter and output registers.

## Test plan
- Single triangle outline, DIM=64, `fill_en`=1, `row_ready`=1:
  - Row 10 has bits 5 and 40 set, so `row_data` for row 10 = bits 5..40 set.
  - Empty rows = 0.
  - Exactly 64 handshakes, `done` at cycle 129 after `start`.
- `fill_en`=0 with a random bitmap: every `row_data` equals the matching slice of the captured buffer, `row_y` runs 0..63 in order.
- Backpressure: random `row_ready` (30% high) gives data stable while valid, no dropped or duplicated rows, and `done` only after row 63 is accepted.
- `SKIP_EMPTY`=1 with only rows 3 and 62 set: exactly two handshakes (y=3, y=62), then `done`.
- Mutate `line_buffer` and pulse `start` mid-frame: the output still matches the original snapshot and the second `start` has no effect.
- Assert `rst` during EMIT of row 20: next cycle all outputs are 0 and IDLE; no `done`. A fresh `start` then runs a complete frame from row 0.
